pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage that sits directly upstream of the instruction ROM in the single-cycle CPU.
- Drives the ROM word address every cycle and receives the fetched instruction back combinationally.
- Decodes only the control-flow opcodes (j, jal, beq, bne, jr) and computes the next PC.
- Registers the PC, detects illegal fetch targets, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ROM_DEPTH, 32: instruction ROM depth in words; the legal fetch range is byte addresses [0, ROM_DEPTH*4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst  input  32  instruction currently returned by the ROM for address pc.
- rs_data  input  32  register-file read of the rs field; used as the jr target.
- zero  input  1  ALU equality flag for the current instruction (1 = operands equal).
- stall  input  1  holds the PC and counter for this cycle.
- pc  output  32  current PC; feeds the ROM addr port.
- pc_plus4  output  32  pc + 4; this is the jal link value for register 31.
- fault  output  1  sticky flag set on an illegal next-PC.
- instret  output  32  count of retired instructions.

Behaviour:
- Reset (asynchronous, rst_n = 0): pc = RESET_PC, fault = 0, instret = 0. Reset overrides everything, including mid-stall and faulted states.
- Combinational next-PC selection, in priority order by decoded inst:
  - opcode 000010 (j) or 000011 (jal): {pc_plus4[31:28], inst[25:0], 2'b00}.
  - opcode 000000 with funct 001000 (jr): rs_data.
  - opcode 000100 (beq) with zero = 1, or opcode 000101 (bne) with zero = 0: pc_plus4 + (sign-extended inst[15:0] << 2).
  - Any other instruction, including a not-taken branch: pc_plus4.
- All arithmetic is 32-bit modulo 2^32; overflow wraps silently before the range check.
- pc_plus4 is purely combinational from pc. The link value is produced even for non-jal instructions; writing it is the register file's decision.
- Illegal next-PC: next_pc[1:0] != 0, or next_pc >= ROM_DEPTH*4 (unsigned compare).
- Rising edge with fault = 1: nothing changes. pc holds at the offending instruction's address and instret is frozen until reset.
- Rising edge with fault = 0 and stall = 1: pc and instret hold. Illegal-target detection is suppressed in a stalled cycle.
- Rising edge with fault = 0, stall = 0, legal next_pc: pc <= next_pc, instret <= instret + 1 (wraps from FFFF_FFFF to 0).
- Rising edge with fault = 0, stall = 0, illegal next_pc: fault <= 1, pc unchanged, instret unchanged.
- Latency: next_pc is visible on pc one clock after the instruction is presented. There are no delay slots and no bubbles.
- Unknown opcodes are treated as sequential; no fault is raised for them.
- State summary: RUN (fault = 0) -> FAULT (fault = 1) only on an illegal target; FAULT -> RUN only via rst_n.

Test Plan:
- Reset then release, ROM at 0x00 holds 0x08000005 (j 5) -> pc = 0x00 during reset, pc = 0x14 after the first edge, instret = 1.
- pc = 0x30, inst = 0x0C000002 (jal 2) -> pc_plus4 = 0x34 before the edge, pc = 0x08 after; then inst = 0x03E00008 (jr) with rs_data = 0x34 -> pc = 0x34.
- pc = 0x40, inst = 0x10221234 (beq), zero = 0 -> pc = 0x44. Then inst = 0x1424FFEE (bne), zero = 0 -> pc = 0x00 (0x48 - 0x48).
- pc = 0x40, beq 0x10221234 with zero = 1 -> target 0x4914 is out of range: fault = 1, pc stays 0x40, instret unchanged; 5 further edges leave all outputs unchanged.
- jr with rs_data = 0x36 -> misaligned target: fault = 1. Same jr with stall = 1 -> no fault, pc holds.
- Stall held high for 3 cycles mid-sequence -> pc and instret constant throughout. Assert rst_n = 0 asynchronously between edges while faulted -> fault = 0 and pc = RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and next-PC stage that sits directly in front of the
// instruction ROM of the single-cycle CPU. It drives the ROM word address
// (pc) every cycle and receives the fetched instruction back in the same
// cycle. Only the control-flow opcodes (j, jal, beq, bne, jr) are decoded;
// everything else advances sequentially.
//
// Once an illegal fetch target is produced (misaligned or outside the ROM),
// the unit freezes in a sticky fault state until reset.
//
// Parameters:
//   RESET_PC   PC loaded on reset.
//   ROM_DEPTH  ROM depth in words; legal byte addresses are [0, ROM_DEPTH*4).
//
// Ports:
//   clk       in   1   system clock, rising-edge active
//   rst_n     in   1   asynchronous active-low reset
//   inst      in  32   instruction returned by the ROM for address pc
//   rs_data   in  32   register-file read of rs; jr target
//   zero      in   1   ALU equality flag (1 = operands equal)
//   stall     in   1   hold pc and instret this cycle
//   pc        out 32   current PC, ROM address
//   pc_plus4  out 32   pc + 4, also the jal link value
//   fault     out  1   sticky illegal-target flag
//   instret   out 32   retired-instruction count
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned ROM_DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic [31:0] rs_data,
   input  logic        zero,
   input  logic        stall,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fault,
   output logic [31:0] instret
);

   localparam logic [31:0] PC_LIMIT = ROM_DEPTH * 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] FN_JR    = 6'b001000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instret;

   state_t      w_state_next;
   logic [31:0] w_pc_next;
   logic [31:0] w_instret_next;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;
   logic [31:0] w_br_offset;
   logic        w_target_ok;
   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;

   assign w_opcode    = inst[31:26];
   assign w_funct     = inst[5:0];
   assign w_pc_plus4  = r_pc + 32'd4;
   // Sign-extended word offset, shifted to a byte offset.
   assign w_br_offset = {{14{inst[15]}}, inst[15:0], 2'b00};

   // Target selection in decode priority order. Adds wrap modulo 2^32
   // before the range check below sees them.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      w_target = w_pc_plus4;
      if (w_opcode == OP_J || w_opcode == OP_JAL) begin
         w_target = {w_pc_plus4[31:28], inst[25:0], 2'b00};
      end else if (w_opcode == OP_RTYPE && w_funct == FN_JR) begin
         w_target = rs_data;
      end else if ((w_opcode == OP_BEQ && zero) ||
                   (w_opcode == OP_BNE && !zero)) begin
         w_target = w_pc_plus4 + w_br_offset;
      end
   end

   assign w_target_ok = (w_target[1:0] == 2'b00) && (w_target < PC_LIMIT);

   // Next-state logic. A stalled cycle never looks at the target, so an
   // illegal target only faults once the instruction would actually retire.
   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_instret_next = r_instret;
      case (r_state)
         ST_RUN: begin
            if (!stall) begin
               if (w_target_ok) begin
                  w_pc_next      = w_target;
                  w_instret_next = r_instret + 32'd1;
               end else begin
                  w_state_next = ST_FAULT;
               end
            end
         end
         ST_FAULT: begin
            // Frozen until reset: pc keeps the offending instruction's address.
         end
         default: begin
            w_state_next = ST_FAULT;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         r_pc      <= RESET_PC;
         r_instret <= 32'd0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_instret <= w_instret_next;
      end
   end

   assign pc       = r_pc;
   assign pc_plus4 = w_pc_plus4;
   assign fault    = (r_state == ST_FAULT);
   assign instret  = r_instret;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit with default parameters (RESET_PC = 0,
// ROM_DEPTH = 32, legal range 0x00..0x7C). Inputs change 1 ns after a rising
// edge; outputs are checked there, away from the active edge. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst;
   logic [31:0] rs_data;
   logic        zero;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fault;
   logic [31:0] instret;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] I_J5    = 32'h0800_0005;
   localparam logic [31:0] I_J12   = 32'h0800_000C;
   localparam logic [31:0] I_J16   = 32'h0800_0010;
   localparam logic [31:0] I_JAL2  = 32'h0C00_0002;
   localparam logic [31:0] I_JR    = 32'h03E0_0008;
   localparam logic [31:0] I_BEQ   = 32'h1022_1234;
   localparam logic [31:0] I_BNE   = 32'h1424_FFEE;
   localparam logic [31:0] I_UNK   = 32'hFC00_0000;
   localparam logic [31:0] I_ADD   = 32'h0022_1020;
   localparam logic [31:0] I_NOP   = 32'h0000_0000;

   pc_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .ROM_DEPTH (32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .inst     (inst),
      .rs_data  (rs_data),
      .zero     (zero),
      .stall    (stall),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .fault    (fault),
      .instret  (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic [31:0] exp_pc,
                              input logic exp_fault, input logic [31:0] exp_ret);
      check({tag, ".pc"},      pc,               exp_pc);
      check({tag, ".fault"},   {31'd0, fault},   {31'd0, exp_fault});
      check({tag, ".instret"}, instret,          exp_ret);
   endtask

   // Present one instruction, let one rising edge pass, settle 1 ns.
   task automatic step(input logic [31:0] i, input logic [31:0] rs,
                       input logic z, input logic s);
      inst    = i;
      rs_data = rs;
      zero    = z;
      stall   = s;
      @(posedge clk);
      #1;
   endtask

   // Assert reset between clock edges and check its effect before any edge.
   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      check_state(tag, 32'h0, 1'b0, 32'd0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b0;
      inst    = I_J5;
      rs_data = 32'h0;
      zero    = 1'b0;
      stall   = 1'b0;

      // Reset holds across an edge.
      @(posedge clk);
      #1;
      check_state("reset", 32'h0, 1'b0, 32'd0);
      check("reset.pc_plus4", pc_plus4, 32'h4);
      rst_n = 1'b1;

      // j 5 from 0x00.
      step(I_J5, 32'h0, 1'b0, 1'b0);
      check_state("j5", 32'h14, 1'b0, 32'd1);

      // j 12 to reach 0x30.
      step(I_J12, 32'h0, 1'b0, 1'b0);
      check_state("j12", 32'h30, 1'b0, 32'd2);

      // jal 2: link value visible before the edge.
      inst = I_JAL2;
      #1;
      check("jal.pc_plus4", pc_plus4, 32'h34);
      step(I_JAL2, 32'h0, 1'b0, 1'b0);
      check_state("jal", 32'h08, 1'b0, 32'd3);

      // jr $31 back to the link address.
      step(I_JR, 32'h34, 1'b0, 1'b0);
      check_state("jr", 32'h34, 1'b0, 32'd4);

      // Three stalled cycles hold everything.
      for (int k = 0; k < 3; k++) begin
         step(I_J16, 32'h0, 1'b0, 1'b1);
         check_state("stall", 32'h34, 1'b0, 32'd4);
      end
      step(I_J16, 32'h0, 1'b0, 1'b0);
      check_state("unstall", 32'h40, 1'b0, 32'd5);

      // beq not taken, then bne taken backwards: 0x48 - 0x48 = 0.
      step(I_BEQ, 32'h0, 1'b0, 1'b0);
      check_state("beq_nt", 32'h44, 1'b0, 32'd6);
      step(I_BNE, 32'h0, 1'b0, 1'b0);
      check_state("bne_t", 32'h00, 1'b0, 32'd7);

      // Unknown opcode and a non-jr R-type advance sequentially.
      step(I_UNK, 32'h0, 1'b0, 1'b0);
      check_state("unknown", 32'h04, 1'b0, 32'd8);
      step(I_ADD, 32'h7C, 1'b0, 1'b0);
      check_state("add", 32'h08, 1'b0, 32'd9);

      // jr to the last legal word.
      step(I_JR, 32'h7C, 1'b0, 1'b0);
      check_state("jr_last", 32'h7C, 1'b0, 32'd10);

      // Misaligned jr while stalled: no fault.
      step(I_JR, 32'h36, 1'b0, 1'b1);
      check_state("jr_mis_stall", 32'h7C, 1'b0, 32'd10);
      // Same jr unstalled: fault, pc and instret hold.
      step(I_JR, 32'h36, 1'b0, 1'b0);
      check_state("jr_mis", 32'h7C, 1'b1, 32'd10);

      async_reset("areset1");

      // Back to 0x40, then a taken beq to 0x4914 (out of range).
      step(I_J16, 32'h0, 1'b0, 1'b0);
      check_state("j16", 32'h40, 1'b0, 32'd1);
      step(I_BEQ, 32'h0, 1'b1, 1'b0);
      check_state("beq_oor", 32'h40, 1'b1, 32'd1);

      // Faulted: five edges with varied inputs change nothing.
      for (int k = 0; k < 5; k++) begin
         step((k % 2 == 0) ? I_J5 : I_NOP, 32'h10, k[0], k[1]);
         check_state("frozen", 32'h40, 1'b1, 32'd1);
         check("frozen.pc_plus4", pc_plus4, 32'h44);
      end

      async_reset("areset2");

      // Sequential step off the end of the ROM: 0x7C + 4 = 0x80 is illegal.
      step(I_JR, 32'h7C, 1'b0, 1'b0);
      check_state("jr_last2", 32'h7C, 1'b0, 32'd1);
      step(I_NOP, 32'h0, 1'b0, 1'b0);
      check_state("seq_oor", 32'h7C, 1'b1, 32'd1);

      async_reset("areset3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
